// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add unsigned 32x32 multiply sequenced over a shared ALU
// Produces the low 32 product bits plus an exact overflow flag; one ALU op per granted cycle.
module alu_mul_sequencer #(
    parameter logic [3:0] OP_ADD = 4'h2,
    parameter logic [3:0] OP_SLL = 4'h5,
    parameter logic [3:0] OP_SRL = 4'h6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        mul_ovf,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHM  = 3'd2,
        S_SHQ  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_p;
    logic [31:0] r_m;
    logic [31:0] r_q;
    logic [31:0] r_result;
    logic        r_ovf;
    logic        r_mul_ovf;
    logic        w_shift_loss;

    // An M bit shifted out is only lost if multiplier bits above the current one are still pending.
    assign w_shift_loss = r_m[31] & (r_q[31:1] != 31'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_p       <= 32'd0;
            r_m       <= 32'd0;
            r_q       <= 32'd0;
            r_result  <= 32'd0;
            r_ovf     <= 1'b0;
            r_mul_ovf <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p   <= 32'd0;
                        r_m   <= opa;
                        r_q   <= opb;
                        r_ovf <= 1'b0;
                    end
                end
                S_ADD: begin
                    if (alu_gnt) begin
                        r_p   <= alu_result;
                        r_ovf <= r_ovf | alu_carryout;
                    end
                end
                S_SHM: begin
                    if (alu_gnt) begin
                        r_m   <= alu_result;
                        r_ovf <= r_ovf | w_shift_loss;
                    end
                end
                S_SHQ: begin
                    if (alu_gnt) begin
                        r_q <= alu_result;
                    end
                end
                S_FIN: begin
                    r_result  <= r_p;
                    r_mul_ovf <= r_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (opb == 32'd0)
                        w_next = S_FIN;
                    else if (opb[0])
                        w_next = S_ADD;
                    else
                        w_next = S_SHM;
                end
            end
            S_ADD: if (alu_gnt) w_next = S_SHM;
            S_SHM: if (alu_gnt) w_next = S_SHQ;
            S_SHQ: begin
                if (alu_gnt) begin
                    if (alu_zero)
                        w_next = S_FIN;
                    else if (alu_result[0])
                        w_next = S_ADD;
                    else
                        w_next = S_SHM;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // In FIN the freshly finished product bypasses the result register so done and data align.
    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_FIN);
        result  = (r_state == S_FIN) ? r_p : r_result;
        mul_ovf = (r_state == S_FIN) ? r_ovf : r_mul_ovf;
        alu_req = 1'b0;
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_op  = 4'd0;
        case (r_state)
            S_ADD: begin
                alu_req = 1'b1;
                alu_a   = r_p;
                alu_b   = r_m;
                alu_op  = OP_ADD;
            end
            S_SHM: begin
                alu_req = 1'b1;
                alu_a   = r_m;
                alu_b   = 32'd1;
                alu_op  = OP_SLL;
            end
            S_SHQ: begin
                alu_req = 1'b1;
                alu_a   = r_q;
                alu_b   = 32'd1;
                alu_op  = OP_SRL;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed vector bench for alu_mul_sequencer with a behavioural ALU
module tb_alu_mul_sequencer;

    localparam logic [3:0] C_ADD = 4'h2;
    localparam logic [3:0] C_SLL = 4'h5;
    localparam logic [3:0] C_SRL = 4'h6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        mul_ovf;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_carryout;
    logic        alu_zero;

    alu_mul_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opa          (opa),
        .opb          (opb),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mul_ovf      (mul_ovf),
        .alu_req      (alu_req),
        .alu_gnt      (alu_gnt),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU as seen by the sequencer.
    always_comb begin
        alu_result   = 32'd0;
        alu_carryout = 1'b0;
        case (alu_op)
            C_ADD:   {alu_carryout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            C_SLL:   alu_result = alu_a << alu_b[4:0];
            C_SRL:   alu_result = alu_a >> alu_b[4:0];
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        o;
        int          lat;
    } vec_t;

    vec_t       vt[10];
    int         total = 0;
    int         bad = 0;
    int         n_req;
    int         n_frz_bad;
    logic [3:0] ops[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Drives one multiply from IDLE and returns at the negedge of the done cycle (lat=0 on timeout).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int st_lo,
                           input int st_hi, input bit noise, output int lat,
                           output logic [31:0] res, output logic ovf);
        logic [31:0] frz_a;
        logic [3:0]  frz_op;
        n_req = 0;
        n_frz_bad = 0;
        ops.delete();
        frz_a = 32'd0;
        frz_op = 4'd0;
        lat = 0;
        res = 32'hdeadbeef;
        ovf = 1'bx;
        @(negedge clk);
        opa = a;
        opb = b;
        start = 1'b1;
        alu_gnt = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            alu_gnt = !(k >= st_lo && k <= st_hi);
            start = noise;
            if (noise) begin
                opa = 32'h9;
                opb = 32'h9;
            end
            if (done) begin
                lat = k;
                res = result;
                ovf = mul_ovf;
                break;
            end
            if (alu_req) n_req++;
            if (alu_req && alu_gnt) ops.push_back(alu_op);
            if (k == st_lo) begin
                frz_a = alu_a;
                frz_op = alu_op;
            end else if (k > st_lo && k <= st_hi) begin
                if (alu_a !== frz_a || alu_op !== frz_op || alu_req !== 1'b1) n_frz_bad++;
            end
        end
        alu_gnt = 1'b1;
    endtask

    int          lat;
    logic [31:0] res;
    logic        ovf;
    logic [3:0]  exp_ops[7];
    int          n_done;

    initial begin
        vt[0] = '{32'd5,        32'd4,        32'd20,         1'b0, 8};
        vt[1] = '{32'd1023,     32'd0,        32'd0,          1'b0, 1};
        vt[2] = '{32'h00010000, 32'h00010000, 32'h00000000,   1'b1, 36};
        vt[3] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   1'b0, 4};
        vt[4] = '{32'd7,        32'd3,        32'd21,         1'b0, 7};
        vt[5] = '{32'd2,        32'd2,        32'd4,          1'b0, 6};
        vt[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   1'b1, 97};
        vt[7] = '{32'h80000000, 32'd2,        32'h00000000,   1'b1, 6};
        vt[8] = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000,   1'b0, 49};
        vt[9] = '{32'h60000000, 32'd3,        32'h20000000,   1'b1, 7};
        exp_ops = '{C_SLL, C_SRL, C_SLL, C_SRL, C_ADD, C_SLL, C_SRL};

        reset = 1'b1;
        start = 1'b0;
        opa = 32'd0;
        opb = 32'd0;
        alu_gnt = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", 32'(mul_ovf), 32'd0);
        check("rst_req", 32'(alu_req), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_mul(vt[i].a, vt[i].b, 0, -1, 1'b0, lat, res, ovf);
            check($sformatf("v%0d_result", i), res, vt[i].r);
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].o));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_held", i), result, vt[i].r);
        end

        run_mul(32'd5, 32'd4, 0, -1, 1'b0, lat, res, ovf);
        check("seq_len", 32'(ops.size()), 32'd7);
        for (int i = 0; i < 7 && i < ops.size(); i++)
            check($sformatf("seq_op%0d", i), 32'(ops[i]), 32'(exp_ops[i]));
        @(negedge clk);

        run_mul(32'd1023, 32'd0, 0, -1, 1'b0, lat, res, ovf);
        check("zero_req", 32'(n_req), 32'd0);
        @(negedge clk);
        check("zero_busy_c2", 32'(busy), 32'd0);
        check("zero_done_c2", 32'(done), 32'd0);

        run_mul(32'd7, 32'd3, 2, 4, 1'b0, lat, res, ovf);
        check("stall_lat", 32'(lat), 32'd10);
        check("stall_result", res, 32'd21);
        check("stall_frozen", 32'(n_frz_bad), 32'd0);
        @(negedge clk);

        run_mul(32'd7, 32'd3, 0, -1, 1'b1, lat, res, ovf);
        check("noise_lat", 32'(lat), 32'd7);
        check("noise_result", res, 32'd21);
        @(negedge clk);
        start = 1'b0;
        check("fin_start_ignored", 32'(busy), 32'd0);
        check("noise_held", result, 32'd21);
        run_mul(32'd2, 32'd2, 0, -1, 1'b0, lat, res, ovf);
        check("after_busy_result", res, 32'd4);
        @(negedge clk);

        @(negedge clk);
        opa = 32'd5;
        opb = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_req", 32'(alu_req), 32'd0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_rst_no_done", 32'(n_done), 32'd0);
        run_mul(32'd2, 32'd2, 0, -1, 1'b0, lat, res, ovf);
        check("post_rst_result", res, 32'd4);
        check("post_rst_lat", 32'(lat), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
